// File: rtl/ip_rx_header_check.sv
`default_nettype none
// ============================================================================
// Module   : ip_rx_header_check
// Brief    : IPv4 receive header validator; forwards the payload of accepted
//            packets and reports a reason code for rejected ones.
// Revision : 1.0 - initial release
// ============================================================================
module ip_rx_header_check #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_0102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_last,
    output logic        hdr_ok,
    output logic        hdr_err,
    output logic [2:0]  err_code,
    output logic [31:0] src_ip,
    output logic [7:0]  protocol,
    output logic [15:0] pld_len,
    output logic [7:0]  pld_data,
    output logic        pld_valid,
    output logic        pld_last,
    output logic        pld_err
);
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_hdr     = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;
    localparam logic [1:0] c_st_drop    = 2'd3;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [20:0] r_acc;
    logic [7:0]  r_hi;
    logic [3:0]  r_ihl;
    logic [15:0] r_tl;
    logic        r_mf;
    logic [12:0] r_frag_off;
    logic [7:0]  r_proto;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_pcnt;

    logic        w_byte0_bad;
    logic [5:0]  w_last_idx;
    logic        w_hdr_end;
    logic [20:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic        w_csum_ok;
    logic [31:0] w_dst;
    logic [15:0] w_hdr_len;
    logic [15:0] w_pld_len;
    logic [2:0]  w_code;

    assign w_byte0_bad = (rx_data[7:4] != 4'd4) || (rx_data[3:0] < 4'd5);
    assign w_last_idx  = {r_ihl, 2'b00} - 6'd1;
    assign w_hdr_end   = (r_cnt == w_last_idx);

    // The last header byte is always odd, so its word joins the sum here.
    assign w_sum     = r_acc + {5'd0, r_hi, rx_data};
    assign w_fold1   = {1'b0, w_sum[15:0]} + {12'd0, w_sum[20:16]};
    assign w_fold2   = w_fold1[15:0] + {15'd0, w_fold1[16]};
    assign w_csum_ok = (w_fold2 == 16'hFFFF);

    // With IHL 5 the final destination octet arrives on the verdict byte.
    assign w_dst     = (r_cnt == 6'd19) ? {r_dst[23:0], rx_data} : r_dst;
    assign w_hdr_len = {10'd0, r_ihl, 2'b00};
    assign w_pld_len = r_tl - w_hdr_len;

    always_comb begin
        w_code = 3'd0;
        if (!w_csum_ok)
            w_code = 3'd2;
        else if (r_tl < w_hdr_len)
            w_code = 3'd3;
        else if (r_mf || (r_frag_off != 13'd0))
            w_code = 3'd4;
        else if ((w_dst != LOCAL_IP) && (w_dst != 32'hFFFF_FFFF))
            w_code = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 6'd0;
            r_acc      <= 21'd0;
            r_hi       <= 8'd0;
            r_ihl      <= 4'd0;
            r_tl       <= 16'd0;
            r_mf       <= 1'b0;
            r_frag_off <= 13'd0;
            r_proto    <= 8'd0;
            r_src      <= 32'd0;
            r_dst      <= 32'd0;
            r_pcnt     <= 16'd0;
            hdr_ok     <= 1'b0;
            hdr_err    <= 1'b0;
            err_code   <= 3'd0;
            src_ip     <= 32'd0;
            protocol   <= 8'd0;
            pld_len    <= 16'd0;
            pld_data   <= 8'd0;
            pld_valid  <= 1'b0;
            pld_last   <= 1'b0;
            pld_err    <= 1'b0;
        end else begin
            hdr_ok    <= 1'b0;
            hdr_err   <= 1'b0;
            pld_valid <= 1'b0;
            pld_last  <= 1'b0;
            pld_err   <= 1'b0;
            if (rx_valid && rx_sof) begin
                // A new header abandons an unfinished payload.
                if (r_state == c_st_payload)
                    pld_err <= 1'b1;
                r_acc <= 21'd0;
                r_hi  <= rx_data;
                r_cnt <= 6'd1;
                r_ihl <= rx_data[3:0];
                if (w_byte0_bad) begin
                    hdr_err  <= 1'b1;
                    err_code <= 3'd1;
                    r_state  <= rx_last ? c_st_idle : c_st_drop;
                end else if (rx_last) begin
                    hdr_err  <= 1'b1;
                    err_code <= 3'd6;
                    r_state  <= c_st_idle;
                end else begin
                    r_state <= c_st_hdr;
                end
            end else if (rx_valid) begin
                case (r_state)
                    c_st_hdr: begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt[0])
                            r_acc <= w_sum;
                        else
                            r_hi <= rx_data;
                        case (r_cnt)
                            6'd2: r_tl[15:8] <= rx_data;
                            6'd3: r_tl[7:0]  <= rx_data;
                            6'd6: begin
                                r_mf              <= rx_data[5];
                                r_frag_off[12:8]  <= rx_data[4:0];
                            end
                            6'd7: r_frag_off[7:0] <= rx_data;
                            6'd9: r_proto <= rx_data;
                            6'd12, 6'd13, 6'd14, 6'd15: r_src <= {r_src[23:0], rx_data};
                            6'd16, 6'd17, 6'd18, 6'd19: r_dst <= {r_dst[23:0], rx_data};
                            default: ;
                        endcase
                        if (w_hdr_end) begin
                            if (w_code != 3'd0) begin
                                hdr_err  <= 1'b1;
                                err_code <= w_code;
                                r_state  <= rx_last ? c_st_idle : c_st_drop;
                            end else begin
                                hdr_ok   <= 1'b1;
                                err_code <= 3'd0;
                                src_ip   <= r_src;
                                protocol <= r_proto;
                                pld_len  <= w_pld_len;
                                r_pcnt   <= 16'd0;
                                if (rx_last)
                                    r_state <= c_st_idle;
                                else if (w_pld_len == 16'd0)
                                    r_state <= c_st_drop;
                                else
                                    r_state <= c_st_payload;
                            end
                        end else if (rx_last) begin
                            hdr_err  <= 1'b1;
                            err_code <= 3'd6;
                            r_state  <= c_st_idle;
                        end
                    end
                    c_st_payload: begin
                        pld_data  <= rx_data;
                        pld_valid <= 1'b1;
                        r_pcnt    <= r_pcnt + 16'd1;
                        if (r_pcnt == pld_len - 16'd1) begin
                            pld_last <= 1'b1;
                            r_state  <= rx_last ? c_st_idle : c_st_drop;
                        end else if (rx_last) begin
                            pld_last <= 1'b1;
                            pld_err  <= 1'b1;
                            r_state  <= c_st_idle;
                        end
                    end
                    c_st_drop: begin
                        if (rx_last)
                            r_state <= c_st_idle;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
